// File: rtl/debug_dump_tx.sv
// Debug frame serializer: streams a header, snapshot PC/cycle counter, register file,
// data memory and an XOR checksum through a unit-wide UART start/done handshake.
module debug_dump_tx #(
    parameter int NB_WORD = 32,
    parameter int NB_UART = 8,
    parameter int N_REGS  = 32,
    parameter int N_MEM   = 16,
    parameter int HEADER  = 'hA5,
    localparam int NB_RA  = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_dump_req,
    input  logic [NB_WORD-1:0] i_pc,
    input  logic [NB_WORD-1:0] i_clk_counter,
    output logic [NB_RA-1:0]   o_reg_addr,
    input  logic [NB_WORD-1:0] i_reg_data,
    output logic [NB_WORD-1:0] o_mem_addr,
    input  logic [NB_WORD-1:0] i_mem_data,
    output logic               o_tx_start,
    output logic [NB_UART-1:0] o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_dump_done
);

    localparam int K       = NB_WORD / NB_UART;
    localparam int N_WORDS = 2 + N_REGS + N_MEM;
    localparam int NB_WC   = $clog2(N_WORDS + 1);
    localparam int NB_UC   = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_HDR, PH_WORD, PH_SUM} phase_t;

    state_t             state;
    phase_t             phase;
    logic [NB_WC-1:0]   word_cnt;
    logic [NB_UC-1:0]   unit_cnt;
    logic [NB_WORD-1:0] shift_reg;
    logic [NB_WORD-1:0] snap_pc;
    logic [NB_WORD-1:0] snap_cnt;
    logic [NB_UART-1:0] checksum;

    logic [NB_WORD-1:0] load_word;
    int                 next_wc;
    logic [NB_RA-1:0]   next_reg_addr;
    logic [NB_WORD-1:0] next_mem_addr;

    // Word index 0/1 are the snapshots, then registers, then memory.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        load_word = i_mem_data;
        if (int'(word_cnt) == 0)
            load_word = snap_pc;
        else if (int'(word_cnt) == 1)
            load_word = snap_cnt;
        else if (int'(word_cnt) < 2 + N_REGS)
            load_word = i_reg_data;
    end

    always_comb begin
        next_wc       = int'(word_cnt) + 1;
        next_reg_addr = NB_RA'(next_wc - 2);
        next_mem_addr = NB_WORD'((next_wc - 2 - N_REGS) * 4);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: all state here is updated with non-blocking assignments so every
            // read in this block sees the pre-edge value.
            state       <= ST_IDLE;
            phase       <= PH_HDR;
            word_cnt    <= '0;
            unit_cnt    <= '0;
            shift_reg   <= '0;
            snap_pc     <= '0;
            snap_cnt    <= '0;
            checksum    <= '0;
            o_reg_addr  <= '0;
            o_mem_addr  <= '0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= '0;
            o_busy      <= 1'b0;
            o_dump_done <= 1'b0;
        end else begin
            o_tx_start  <= 1'b0;
            o_dump_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_dump_req) begin
                        snap_pc    <= i_pc;
                        snap_cnt   <= i_clk_counter;
                        o_tx_data  <= NB_UART'(HEADER);
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        phase      <= PH_HDR;
                        state      <= ST_SEND;
                    end
                end
                ST_LOAD: begin
                    o_tx_data  <= load_word[NB_UART-1:0];
                    shift_reg  <= load_word >> NB_UART;
                    unit_cnt   <= '0;
                    o_tx_start <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (phase == PH_WORD)
                        checksum <= checksum ^ o_tx_data;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        unique case (phase)
                            PH_HDR: begin
                                phase    <= PH_WORD;
                                word_cnt <= '0;
                                state    <= ST_LOAD;
                            end
                            PH_WORD: begin
                                if (int'(unit_cnt) < K - 1) begin
                                    unit_cnt   <= unit_cnt + NB_UC'(1);
                                    o_tx_data  <= shift_reg[NB_UART-1:0];
                                    shift_reg  <= shift_reg >> NB_UART;
                                    o_tx_start <= 1'b1;
                                    state      <= ST_SEND;
                                end else if (int'(word_cnt) < N_WORDS - 1) begin
                                    // Address is registered so the read data is valid during LOAD.
                                    if (next_wc >= 2 && next_wc < 2 + N_REGS)
                                        o_reg_addr <= next_reg_addr;
                                    else if (next_wc >= 2 + N_REGS)
                                        o_mem_addr <= next_mem_addr;
                                    word_cnt <= word_cnt + NB_WC'(1);
                                    state    <= ST_LOAD;
                                end else begin
                                    phase      <= PH_SUM;
                                    o_tx_data  <= checksum;
                                    o_tx_start <= 1'b1;
                                    state      <= ST_SEND;
                                end
                            end
                            PH_SUM: begin
                                o_dump_done <= 1'b1;
                                state       <= ST_DONE;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_DONE: begin
                    o_busy   <= 1'b0;
                    checksum <= '0;
                    word_cnt <= '0;
                    unit_cnt <= '0;
                    phase    <= PH_HDR;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: a default-sized instance (full frames, interference, reset)
// and a 16-bit/2-register instance driven from a table of hand-computed frames.
module tb_debug_dump_tx;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Instance A: default parameters
    logic        a_req;
    logic [31:0] a_pc, a_cnt;
    logic [4:0]  a_reg_addr;
    logic [31:0] a_reg_data, a_mem_addr, a_mem_data;
    logic        a_tx_start, a_busy, a_done;
    logic [7:0]  a_tx_data;
    logic        a_resp_done, a_inj_done, a_idle_done, a_tx_done;
    logic        a_inject_send;

    assign a_reg_data = {27'd0, a_reg_addr};
    assign a_mem_data = 32'h100 + (a_mem_addr >> 2);
    assign a_tx_done  = a_resp_done | a_inj_done | a_idle_done;

    debug_dump_tx dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_dump_req(a_req),
        .i_pc(a_pc), .i_clk_counter(a_cnt),
        .o_reg_addr(a_reg_addr), .i_reg_data(a_reg_data),
        .o_mem_addr(a_mem_addr), .i_mem_data(a_mem_data),
        .o_tx_start(a_tx_start), .o_tx_data(a_tx_data), .i_tx_done(a_tx_done),
        .o_busy(a_busy), .o_dump_done(a_done)
    );

    // Instance B: 16-bit words, two registers, no memory section
    logic        b_req;
    logic [15:0] b_pc, b_cnt;
    logic [0:0]  b_reg_addr;
    logic [15:0] b_reg_data, b_mem_addr, b_mem_data;
    logic [15:0] b_regs [2];
    logic        b_tx_start, b_busy, b_done, b_tx_done;
    logic [7:0]  b_tx_data;

    assign b_reg_data = b_regs[b_reg_addr];
    assign b_mem_data = 16'hDEAD;

    debug_dump_tx #(.NB_WORD(16), .NB_UART(8), .N_REGS(2), .N_MEM(0)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_dump_req(b_req),
        .i_pc(b_pc), .i_clk_counter(b_cnt),
        .o_reg_addr(b_reg_addr), .i_reg_data(b_reg_data),
        .o_mem_addr(b_mem_addr), .i_mem_data(b_mem_data),
        .o_tx_start(b_tx_start), .o_tx_data(b_tx_data), .i_tx_done(b_tx_done),
        .o_busy(b_busy), .o_dump_done(b_done)
    );

    // UART models: answer each start with a done pulse three cycles later
    initial begin
        a_resp_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (a_tx_start) begin
                repeat (3) @(posedge i_clk);
                #1 a_resp_done = 1'b1;
                @(posedge i_clk);
                #1 a_resp_done = 1'b0;
            end
        end
    end

    initial begin
        b_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (b_tx_start) begin
                repeat (3) @(posedge i_clk);
                #1 b_tx_done = 1'b1;
                @(posedge i_clk);
                #1 b_tx_done = 1'b0;
            end
        end
    end

    // Spurious done in the same cycle as every start, when enabled
    initial begin
        a_inj_done = 1'b0;
        forever begin
            @(posedge i_clk);
            #1 a_inj_done = a_inject_send && a_tx_start;
        end
    end

    logic [7:0] a_units [$];
    logic [7:0] b_units [$];
    logic [7:0] a_exp [$];
    int   a_done_cnt = 0;
    int   b_done_cnt = 0;
    int   a_last_tx_done_cyc = 0;
    logic b_mem_touched = 1'b0;

    always @(negedge i_clk) begin
        if (a_tx_start) a_units.push_back(a_tx_data);
        if (b_tx_start) b_units.push_back(b_tx_data);
        if (a_resp_done) a_last_tx_done_cyc <= cyc;
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (b_mem_addr != 16'd0) b_mem_touched <= 1'b1;
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] cnt;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [7:0]  exp [10];
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic a_request();
        a_req = 1'b1;
        @(posedge i_clk);
        #1 a_req = 1'b0;
    endtask

    task automatic check_frame_a(input int start, input string tag);
        check({tag, " unit count"}, 64'(a_units.size() - start), 64'(a_exp.size()));
        for (int i = 0; i < a_exp.size() && start + i < a_units.size(); i++)
            check($sformatf("%s unit[%0d]", tag, i), 64'(a_units[start + i]), 64'(a_exp[i]));
    endtask

    task automatic wait_a_done(input string tag, input bit chk_timing);
        int n = 0;
        while (!a_done && n < 5000) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, " dump_done seen"}, 64'(a_done), 64'(1));
        if (a_done) begin
            check({tag, " busy with dump_done"}, 64'(a_busy), 64'(1));
            if (chk_timing)
                check({tag, " dump_done cycle after last tx_done"}, 64'(cyc), 64'(a_last_tx_done_cyc + 1));
            @(negedge i_clk);
            check({tag, " busy dropped"}, 64'(a_busy), 64'(0));
            check({tag, " dump_done one cycle"}, 64'(a_done), 64'(0));
        end
    endtask

    initial begin
        int start;
        int d0;
        int n;
        logic [31:0] words [$];
        logic [7:0]  sum;

        // Reference frame for instance A, built from the frame layout
        words.push_back(32'h0040_0010);
        words.push_back(32'h0000_002A);
        for (int i = 0; i < 32; i++) words.push_back(32'(i));
        for (int j = 0; j < 16; j++) words.push_back(32'h100 + 32'(j));
        sum = 8'h00;
        a_exp.push_back(8'hA5);
        foreach (words[w]) begin
            for (int u = 0; u < 4; u++) begin
                a_exp.push_back(words[w][8*u +: 8]);
                sum ^= words[w][8*u +: 8];
            end
        end
        a_exp.push_back(sum);

        // Instance B frames; checksum is the XOR of all bytes after A5
        vecs[0].pc = 16'hBEEF; vecs[0].cnt = 16'h0003; vecs[0].r0 = 16'h1234; vecs[0].r1 = 16'h00FF;
        vecs[0].exp = '{8'hA5, 8'hEF, 8'hBE, 8'h03, 8'h00, 8'h34, 8'h12, 8'hFF, 8'h00, 8'h8B};
        vecs[1].pc = 16'h0001; vecs[1].cnt = 16'hFFFF; vecs[1].r0 = 16'hA5A5; vecs[1].r1 = 16'h0000;
        vecs[1].exp = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h01};
        vecs[2].pc = 16'h1357; vecs[2].cnt = 16'h2468; vecs[2].r0 = 16'h8000; vecs[2].r1 = 16'h0001;
        vecs[2].exp = '{8'hA5, 8'h57, 8'h13, 8'h68, 8'h24, 8'h00, 8'h80, 8'h01, 8'h00, 8'h89};

        // Reset with requests held high: they must not be accepted
        i_rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        a_pc = 32'h0040_0010; a_cnt = 32'h0000_002A;
        a_idle_done = 1'b0; a_inject_send = 1'b0;
        b_pc = 16'h0; b_cnt = 16'h0; b_regs[0] = 16'h0; b_regs[1] = 16'h0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        check("reset tx_start", 64'(a_tx_start), 64'(0));
        check("reset tx_data", 64'(a_tx_data), 64'(0));
        check("reset busy", 64'(a_busy), 64'(0));
        check("reset dump_done", 64'(a_done), 64'(0));
        check("reset reg_addr", 64'(a_reg_addr), 64'(0));
        check("reset mem_addr", 64'(a_mem_addr), 64'(0));
        check("reset b busy", 64'(b_busy), 64'(0));
        @(posedge i_clk);
        #1;
        check("req during reset ignored", 64'(a_busy), 64'(0));
        check("no units after reset", 64'(a_units.size()), 64'(0));

        // Frame 1: plain dump with start/end latency checks
        start = a_units.size();
        d0 = a_done_cnt;
        a_request();
        check("latency tx_start", 64'(a_tx_start), 64'(1));
        check("latency busy", 64'(a_busy), 64'(1));
        check("latency header", 64'(a_tx_data), 64'(8'hA5));
        wait_a_done("frame1", 1'b1);
        repeat (5) @(posedge i_clk);
        #1;
        check_frame_a(start, "frame1");
        check("frame1 done pulses", 64'(a_done_cnt - d0), 64'(1));

        // Frame 2: spurious done pulses in IDLE and SEND, second request and PC change mid-frame
        for (int i = 0; i < 3; i++) begin
            a_idle_done = 1'b1;
            @(posedge i_clk);
            #1 a_idle_done = 1'b0;
            @(posedge i_clk);
            #1;
        end
        check("idle done ignored busy", 64'(a_busy), 64'(0));
        check("idle done ignored units", 64'(a_units.size() - start), 64'(a_exp.size()));
        a_inject_send = 1'b1;
        start = a_units.size();
        d0 = a_done_cnt;
        a_request();
        n = 0;
        while (a_units.size() - start < 20 && n < 2000) begin
            @(posedge i_clk);
            #1 n++;
        end
        check("frame2 reached unit 20", 64'(a_units.size() - start >= 20), 64'(1));
        a_pc = 32'hFFFF_FFFF;
        a_cnt = 32'h1234_5678;
        a_request();
        wait_a_done("frame2", 1'b0);
        a_inject_send = 1'b0;
        repeat (30) @(posedge i_clk);
        #1;
        check_frame_a(start, "frame2");
        check("frame2 done pulses", 64'(a_done_cnt - d0), 64'(1));
        check("request not queued", 64'(a_busy), 64'(0));
        a_pc = 32'h0040_0010;
        a_cnt = 32'h0000_002A;

        // Frame 3: reset while waiting after the 5th unit, then a clean restart
        start = a_units.size();
        d0 = a_done_cnt;
        a_request();
        n = 0;
        while (a_units.size() - start < 5 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("abort reached unit 5", 64'(a_units.size() - start), 64'(5));
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        check("abort busy low", 64'(a_busy), 64'(0));
        check("abort no dump_done", 64'(a_done), 64'(0));
        repeat (10) @(posedge i_clk);
        #1;
        check("abort no more units", 64'(a_units.size() - start), 64'(5));
        check("abort done pulses", 64'(a_done_cnt - d0), 64'(0));
        start = a_units.size();
        d0 = a_done_cnt;
        a_request();
        wait_a_done("frame3", 1'b1);
        repeat (5) @(posedge i_clk);
        #1;
        check_frame_a(start, "frame3");
        check("frame3 done pulses", 64'(a_done_cnt - d0), 64'(1));

        // Instance B table
        for (int v = 0; v < 3; v++) begin
            b_pc = vecs[v].pc;
            b_cnt = vecs[v].cnt;
            b_regs[0] = vecs[v].r0;
            b_regs[1] = vecs[v].r1;
            start = b_units.size();
            d0 = b_done_cnt;
            b_req = 1'b1;
            @(posedge i_clk);
            #1 b_req = 1'b0;
            check($sformatf("b%0d latency tx_start", v), 64'(b_tx_start), 64'(1));
            n = 0;
            while (b_done_cnt == d0 && n < 500) begin
                @(posedge i_clk);
                #1 n++;
            end
            check($sformatf("b%0d dump_done seen", v), 64'(b_done_cnt - d0), 64'(1));
            repeat (3) @(posedge i_clk);
            #1;
            check($sformatf("b%0d busy after", v), 64'(b_busy), 64'(0));
            check($sformatf("b%0d unit count", v), 64'(b_units.size() - start), 64'(10));
            for (int i = 0; i < 10 && start + i < b_units.size(); i++)
                check($sformatf("b%0d unit[%0d]", v, i), 64'(b_units[start + i]), 64'(vecs[v].exp[i]));
        end
        check("b mem_addr stays 0", 64'(b_mem_touched), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
